axis_tx_frame_gen: RTL and testbench

Synthesizable Ethernet frame generator that drives the LMAC TX user interface (s_axis_* of the LMAC top) with 64-bit AXI-Stream frames. It is used for bring-up, loopback and throughput tests on ZCU102 without the DMA path. It builds each frame from a programmed header plus an incrementing-byte payload, honours tready backpressure, and sends a programmed number of frames with a configurable inter-frame gap.

---
 rtl/axis_tx_frame_gen_pkg.sv | 18 +
 rtl/axis_tx_frame_gen_beat_builder.sv | 40 ++++
 rtl/axis_tx_frame_gen.sv | 187 ++++++++++++++++++
 tb/tb_axis_tx_frame_gen.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_tx_frame_gen_pkg.sv
// Shared types and helpers for the AXI-Stream Ethernet test-frame generator.
package axis_tx_frame_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int ETH_HDR_LEN = 14;
  localparam int AXIS_BYTES  = 8;

  // Byte enables for a final beat carrying (len % 8) bytes; zero remainder means a full beat.
  function automatic logic [AXIS_BYTES-1:0] keep_from_rem(input logic [2:0] rem);
    return (rem == 3'd0) ? 8'hFF : ~(8'hFF << rem);
  endfunction

endpackage

// File: rtl/axis_tx_frame_gen_beat_builder.sv
// Combinational builder for one 64-bit beat: header bytes, then incrementing payload.
module eth_beat_builder
  import axis_tx_frame_gen_pkg::*;
(
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] ethertype,
  input  logic [7:0]  seed,
  input  logic [15:0] frame_len,
  input  logic [7:0]  frame_lsb,
  input  logic [15:0] beat_idx,
  output logic [63:0] tdata,
  output logic [7:0]  tkeep,
  output logic        tlast
);

  logic [7:0]  hdr_b [ETH_HDR_LEN];
  logic [15:0] base;

  assign hdr_b = '{dst_mac[47:40], dst_mac[39:32], dst_mac[31:24], dst_mac[23:16],
                   dst_mac[15:8],  dst_mac[7:0],   src_mac[47:40], src_mac[39:32],
                   src_mac[31:24], src_mac[23:16], src_mac[15:8],  src_mac[7:0],
                   ethertype[15:8], ethertype[7:0]};

  assign base  = beat_idx << 3;
  assign tlast = (beat_idx == ((frame_len - 16'd1) >> 3));
  assign tkeep = tlast ? keep_from_rem(frame_len[2:0]) : 8'hFF;

  function automatic logic [7:0] frame_byte(input logic [15:0] idx);
    if (idx < 16'(ETH_HDR_LEN))
      return hdr_b[idx[3:0]];
    return seed + frame_lsb + 8'(idx - 16'(ETH_HDR_LEN));
  endfunction

  // Lanes beyond the frame end are forced to zero so the bus is clean on short final beats.
  for (genvar j = 0; j < AXIS_BYTES; j++) begin : g_lane
    assign tdata[8*j +: 8] = tkeep[j] ? frame_byte(base + 16'(j)) : 8'h00;
  end

endmodule

// File: rtl/axis_tx_frame_gen.sv
// Ethernet test-frame generator: N frames of header + incrementing payload with inter-frame gap.
module axis_tx_frame_gen
  import axis_tx_frame_gen_pkg::*;
#(
  parameter int MAX_LEN = 1514,
  parameter int MIN_LEN = 60,
  parameter int GAP_W   = 8
) (
  input  logic             dclk,
  input  logic             rst,
  input  logic             start,
  input  logic [47:0]      dst_mac,
  input  logic [47:0]      src_mac,
  input  logic [15:0]      ethertype,
  input  logic [15:0]      frame_len,
  input  logic [15:0]      num_frames,
  input  logic [7:0]       seed,
  input  logic [GAP_W-1:0] gap_cycles,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [63:0]      m_axis_tdata,
  output logic [7:0]       m_axis_tkeep,
  output logic             m_axis_tlast,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [15:0]      frame_cnt
);

  state_t           state;
  logic [47:0]      dst_q, src_q;
  logic [15:0]      type_q, len_q, nfr_q;
  logic [7:0]       seed_q;
  logic [GAP_W-1:0] gap_q, gap_cnt;
  logic [15:0]      frame_idx, beat_ptr;

  logic             start_ok, handshake, last_frame;
  logic [47:0]      b_dst, b_src;
  logic [15:0]      b_type, b_len, b_frame, b_beat;
  logic [7:0]       b_seed;
  logic [63:0]      b_data;
  logic [7:0]       b_keep;
  logic             b_last;

  assign start_ok   = (frame_len >= 16'(MIN_LEN)) && (frame_len <= 16'(MAX_LEN)) &&
                      (num_frames != 16'd0);
  assign handshake  = m_axis_tvalid & m_axis_tready;
  assign last_frame = (frame_idx + 16'd1 == nfr_q);

  // The builder always computes the beat that will be loaded at the next edge;
  // in IDLE that is beat 0 built straight from the live inputs.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    b_dst   = dst_q;
    b_src   = src_q;
    b_type  = type_q;
    b_len   = len_q;
    b_seed  = seed_q;
    b_frame = frame_idx;
    b_beat  = beat_ptr;
    if (state == ST_IDLE) begin
      b_dst   = dst_mac;
      b_src   = src_mac;
      b_type  = ethertype;
      b_len   = frame_len;
      b_seed  = seed;
      b_frame = 16'd0;
      b_beat  = 16'd0;
    end else if (state == ST_GAP) begin
      b_beat = 16'd0;
    end else if (m_axis_tlast) begin
      b_frame = frame_idx + 16'd1;
      b_beat  = 16'd0;
    end
  end

  eth_beat_builder u_builder (
    .dst_mac   (b_dst),
    .src_mac   (b_src),
    .ethertype (b_type),
    .seed      (b_seed),
    .frame_len (b_len),
    .frame_lsb (b_frame[7:0]),
    .beat_idx  (b_beat),
    .tdata     (b_data),
    .tkeep     (b_keep),
    .tlast     (b_last)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge dclk) begin
    if (rst) begin
      state         <= ST_IDLE;
      dst_q         <= '0;
      src_q         <= '0;
      type_q        <= '0;
      len_q         <= '0;
      nfr_q         <= '0;
      seed_q        <= '0;
      gap_q         <= '0;
      gap_cnt       <= '0;
      frame_idx     <= '0;
      beat_ptr      <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && start_ok) begin
            dst_q         <= dst_mac;
            src_q         <= src_mac;
            type_q        <= ethertype;
            len_q         <= frame_len;
            nfr_q         <= num_frames;
            seed_q        <= seed;
            gap_q         <= gap_cycles;
            frame_idx     <= 16'd0;
            frame_cnt     <= 16'd0;
            beat_ptr      <= 16'd1;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= b_data;
            m_axis_tkeep  <= b_keep;
            m_axis_tlast  <= b_last;
            busy          <= 1'b1;
            state         <= ST_SEND;
          end else if (start) begin
            err <= 1'b1;
          end
        end
        ST_SEND: begin
          if (handshake && m_axis_tlast) begin
            frame_cnt <= frame_cnt + 16'd1;
            if (last_frame || gap_q != '0) begin
              m_axis_tvalid <= 1'b0;
              m_axis_tdata  <= '0;
              m_axis_tkeep  <= '0;
              m_axis_tlast  <= 1'b0;
            end
            if (last_frame) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              frame_idx <= frame_idx + 16'd1;
              if (gap_q != '0) begin
                gap_cnt <= gap_q;
                state   <= ST_GAP;
              end else begin
                beat_ptr     <= 16'd1;
                m_axis_tdata <= b_data;
                m_axis_tkeep <= b_keep;
                m_axis_tlast <= b_last;
              end
            end
          end else if (handshake) begin
            beat_ptr     <= beat_ptr + 16'd1;
            m_axis_tdata <= b_data;
            m_axis_tkeep <= b_keep;
            m_axis_tlast <= b_last;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(1)) begin
            beat_ptr      <= 16'd1;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= b_data;
            m_axis_tkeep  <= b_keep;
            m_axis_tlast  <= b_last;
            state         <= ST_SEND;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_tx_frame_gen.sv
// Scoreboard bench for axis_tx_frame_gen: expected beats are queued at start and popped on handshakes.
module tb_axis_tx_frame_gen;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  logic        dclk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [47:0] dst_mac = '0;
  logic [47:0] src_mac = '0;
  logic [15:0] ethertype = '0;
  logic [15:0] frame_len = 16'd60;
  logic [15:0] num_frames = 16'd1;
  logic [7:0]  seed = '0;
  logic [7:0]  gap_cycles = '0;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tvalid;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        busy, done, err;
  logic [15:0] frame_cnt;

  beat_t sb[$];
  int    vectors = 0;
  int    miscompares = 0;

  always #5 dclk = ~dclk;

  axis_tx_frame_gen dut (
    .dclk          (dclk),
    .rst           (rst),
    .start         (start),
    .dst_mac       (dst_mac),
    .src_mac       (src_mac),
    .ethertype     (ethertype),
    .frame_len     (frame_len),
    .num_frames    (num_frames),
    .seed          (seed),
    .gap_cycles    (gap_cycles),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .frame_cnt     (frame_cnt)
  );

  function automatic logic [7:0] exp_byte(input int i, input int f);
    logic [111:0] hdr;
    hdr = {dst_mac, src_mac, ethertype};
    if (i < 14) return hdr[111-8*i -: 8];
    return 8'(int'(seed) + f + i - 14);
  endfunction

  task automatic push_frames();
    int    nbeats, i;
    beat_t e;
    nbeats = (int'(frame_len) + 7) / 8;
    for (int f = 0; f < int'(num_frames); f++) begin
      for (int b = 0; b < nbeats; b++) begin
        e = '0;
        for (int j = 0; j < 8; j++) begin
          i = b * 8 + j;
          if (i < int'(frame_len)) begin
            e.keep[j]        = 1'b1;
            e.data[8*j +: 8] = exp_byte(i, f);
          end
        end
        e.last = (b == nbeats - 1);
        sb.push_back(e);
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge dclk); #1; start = 1'b1;
    @(posedge dclk); #1; start = 1'b0;
  endtask

  // Runs the stream until done, checking beats, AXIS hold rule and inter-frame gaps.
  task automatic drain(input int budget, input bit rand_ready, input int n_frames,
                       input int exp_gap, output logic [63:0] first_data);
    int          frames_seen, gap_run;
    bit          pending_gap, prev_stall, got_done, got_first;
    logic [73:0] prev_out, cur_out;
    beat_t       exp;
    frames_seen = 0; gap_run = 0; pending_gap = 0; prev_stall = 0;
    got_done = 0; got_first = 0; prev_out = '0; first_data = '0;
    for (int cyc = 0; cyc < budget && !got_done; cyc++) begin
      m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge dclk);
      cur_out = {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast};
      if (prev_stall) begin
        vectors++;
        if (cur_out !== prev_out) begin
          miscompares++;
          $display("FAIL hold_under_stall: got %h required %h", cur_out, prev_out);
        end
      end
      if (pending_gap && m_axis_tvalid) begin
        vectors++;
        if (gap_run != exp_gap) begin
          miscompares++;
          $display("FAIL gap_len: got %0d required %0d", gap_run, exp_gap);
        end
        pending_gap = 0;
      end else if (pending_gap) begin
        gap_run++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (!got_first) begin
          first_data = m_axis_tdata;
          got_first  = 1;
        end
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL extra_beat: got %h/%h/%b required none", m_axis_tdata, m_axis_tkeep, m_axis_tlast);
        end else begin
          exp = sb.pop_front();
          if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== exp) begin
            miscompares++;
            $display("FAIL beat: got %h/%h/%b required %h/%h/%b", m_axis_tdata, m_axis_tkeep,
                     m_axis_tlast, exp.data, exp.keep, exp.last);
          end
        end
        if (m_axis_tlast) begin
          frames_seen++;
          if (frames_seen < n_frames) begin
            pending_gap = 1;
            gap_run     = 0;
          end
        end
      end
      if (done) got_done = 1;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_out   = cur_out;
      @(posedge dclk); #1;
    end
    vectors++;
    if (!got_done) begin
      miscompares++;
      $display("FAIL done_timeout: got no done required done within %0d cycles", budget);
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL missing_beats: got %0d left required 0", sb.size());
    end
    sb.delete();
    @(negedge dclk);
    vectors++;
    if ({done, m_axis_tvalid, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL after_done done/tvalid/busy: got %b required 000", {done, m_axis_tvalid, busy});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge dclk);
    @(negedge dclk);
    vectors++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== 74'd0) begin
      miscompares++;
      $display("FAIL reset_stream: got %b/%h/%h/%b required zeros", m_axis_tvalid, m_axis_tdata,
               m_axis_tkeep, m_axis_tlast);
    end
    vectors++;
    if ({busy, done, err, frame_cnt} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_status: got %b%b%b/%h required zeros", busy, done, err, frame_cnt);
    end
    @(posedge dclk); #1; rst = 1'b0;
  endtask

  task automatic test_single_header();
    logic [63:0] first;
    dst_mac = 48'h001122334455; src_mac = 48'hAABBCCDDEEFF; ethertype = 16'h0800;
    frame_len = 16'd60; num_frames = 16'd1; seed = 8'h00; gap_cycles = 8'd0;
    push_frames();
    pulse_start();
    drain(200, 1'b0, 1, 0, first);
    vectors++;
    if (first !== 64'hBBAA554433221100) begin
      miscompares++;
      $display("FAIL header_beat0: got %h required %h", first, 64'hBBAA554433221100);
    end
    vectors++;
    if (frame_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL single_frame_cnt: got %0d required 1", frame_cnt);
    end
  endtask

  task automatic test_multi_gap();
    logic [63:0] first;
    frame_len = 16'd64; num_frames = 16'd3; seed = 8'hFE; gap_cycles = 8'd4;
    push_frames();
    pulse_start();
    seed = 8'h55; frame_len = 16'd100; dst_mac = 48'hFFFF_FFFF_FFFF; gap_cycles = 8'd1;
    drain(400, 1'b0, 3, 4, first);
    vectors++;
    if (frame_cnt !== 16'd3) begin
      miscompares++;
      $display("FAIL multi_frame_cnt: got %0d required 3", frame_cnt);
    end
    dst_mac = 48'h001122334455;
  endtask

  task automatic test_backpressure();
    logic [63:0] first;
    frame_len = 16'd60; num_frames = 16'd2; seed = 8'h00; gap_cycles = 8'd0;
    push_frames();
    pulse_start();
    drain(800, 1'b1, 2, 0, first);
    vectors++;
    if (frame_cnt !== 16'd2) begin
      miscompares++;
      $display("FAIL bp_frame_cnt: got %0d required 2", frame_cnt);
    end
  endtask

  task automatic test_reject();
    for (int k = 0; k < 3; k++) begin
      frame_len  = (k == 0) ? 16'd59 : (k == 1) ? 16'd1515 : 16'd60;
      num_frames = (k == 2) ? 16'd0 : 16'd1;
      pulse_start();
      @(negedge dclk);
      vectors++;
      if ({err, m_axis_tvalid, busy} !== 3'b100) begin
        miscompares++;
        $display("FAIL reject_%0d err/tvalid/busy: got %b required 100", k, {err, m_axis_tvalid, busy});
      end
      @(posedge dclk); #1;
      @(negedge dclk);
      vectors++;
      if ({err, m_axis_tvalid, busy} !== 3'b000) begin
        miscompares++;
        $display("FAIL reject_%0d_after err/tvalid/busy: got %b required 000", k, {err, m_axis_tvalid, busy});
      end
    end
  endtask

  task automatic test_midframe_reset();
    logic [63:0] first;
    frame_len = 16'd1514; num_frames = 16'd1; seed = 8'h10; gap_cycles = 8'd0;
    push_frames();
    pulse_start();
    m_axis_tready = 1'b1;
    repeat (3) @(posedge dclk);
    #1; m_axis_tready = 1'b0;
    repeat (3) void'(sb.pop_front());
    @(negedge dclk);
    vectors++;
    if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, sb[0].data}) begin
      miscompares++;
      $display("FAIL beat3_present: got %b/%h required 1/%h", m_axis_tvalid, m_axis_tdata, sb[0].data);
    end
    rst = 1'b1;
    @(posedge dclk); #1; rst = 1'b0;
    @(negedge dclk);
    vectors++;
    if ({m_axis_tvalid, busy, m_axis_tdata} !== 66'd0) begin
      miscompares++;
      $display("FAIL midframe_rst tvalid/busy/tdata: got %b/%b/%h required 0/0/0", m_axis_tvalid,
               busy, m_axis_tdata);
    end
    sb.delete();
    frame_len = 16'd60; seed = 8'h33;
    push_frames();
    pulse_start();
    drain(200, 1'b0, 1, 0, first);
    vectors++;
    if (first !== 64'hBBAA554433221100) begin
      miscompares++;
      $display("FAIL restart_header: got %h required %h", first, 64'hBBAA554433221100);
    end
  endtask

  initial begin
    test_reset();
    test_single_header();
    test_multi_gap();
    test_backpressure();
    test_reject();
    test_midframe_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
